// File: rtl/lpm_xor_acc.sv
// lpm_xor_acc -- framed XOR checksum accumulator.
//
// Each accepted beat carries lpm_size words of lpm_width bits. The words of
// one beat are XOR-folded into a single word, and the folded words of a frame
// (sop .. eop) are XOR-accumulated. At eop the checksum is presented on
// result/result_valid together with the saturating beat count, and held until
// downstream takes it with result_ready.
//
// Ports
//   clock         rising-edge clock
//   aclr_n        asynchronous active-low clear
//   data          beat payload, word j at [j*lpm_width +: lpm_width]
//   in_valid      beat valid
//   in_sop        first beat of frame (qualified by in_valid)
//   in_eop        last beat of frame (qualified by in_valid)
//   in_ready      block can accept a beat
//   result        frame checksum (inverted when lpm_mode is "XNOR")
//   result_valid  result / beat_count / cnt_ovf are valid
//   result_ready  downstream accepts the result
//   beat_count    beats in the reported frame (saturating)
//   cnt_ovf       reported frame had more than 2^lpm_cntw-1 beats
//   err_orphan    one-cycle pulse: beat dropped outside a frame
//   err_abort     one-cycle pulse: open frame restarted by a new sop
module lpm_xor_acc #(
   parameter string lpm_type  = "lpm_xor_acc",
   parameter int    lpm_width = 8,
   parameter int    lpm_size  = 4,
   parameter int    lpm_cntw  = 8,
   parameter string lpm_mode  = "XOR",
   parameter string lpm_hint  = "UNUSED"
) (
   input  logic                          clock,
   input  logic                          aclr_n,
   input  logic [lpm_size*lpm_width-1:0] data,
   input  logic                          in_valid,
   input  logic                          in_sop,
   input  logic                          in_eop,
   output logic                          in_ready,
   output logic [lpm_width-1:0]          result,
   output logic                          result_valid,
   input  logic                          result_ready,
   output logic [lpm_cntw-1:0]           beat_count,
   output logic                          cnt_ovf,
   output logic                          err_orphan,
   output logic                          err_abort
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   localparam bit                  xnor_c    = (lpm_mode == "XNOR");
   localparam logic [lpm_cntw-1:0] cnt_one_c = lpm_cntw'(1'b1);
   localparam logic [lpm_cntw-1:0] cnt_max_c = {lpm_cntw{1'b1}};

   // Elaboration-time parameter legality checks.
   if (lpm_width < 1) begin : g_bad_width
      $error("lpm_xor_acc: lpm_width must be at least 1");
   end
   if (lpm_size < 1) begin : g_bad_size
      $error("lpm_xor_acc: lpm_size must be at least 1");
   end
   if (lpm_cntw < 1) begin : g_bad_cntw
      $error("lpm_xor_acc: lpm_cntw must be at least 1");
   end
   if ((lpm_mode != "XOR") && (lpm_mode != "XNOR")) begin : g_bad_mode
      $error("lpm_xor_acc: lpm_mode must be \"XOR\" or \"XNOR\"");
   end
   if (lpm_type == "") begin : g_bad_type
      $error("lpm_xor_acc: lpm_type must not be empty");
   end
   // lpm_hint is informational only; this empty block just references it.
   if (lpm_hint == "") begin : g_hint_empty
   end

   // XOR of all words presented in one beat.
   function automatic logic [lpm_width-1:0] beat_xor(input logic [lpm_size*lpm_width-1:0] d);
      logic [lpm_width-1:0] r;
      r = '0;
      for (int j = 0; j < lpm_size; j++) begin
         r = r ^ d[j*lpm_width +: lpm_width];
      end
      return r;
   endfunction

   // Output polarity; only the reported result is inverted, never the accumulator.
   function automatic logic [lpm_width-1:0] out_pol(input logic [lpm_width-1:0] x);
      return xnor_c ? ~x : x;
   endfunction

   state_t               state_r, state_s;
   logic [lpm_width-1:0] acc_r, acc_s;
   logic [lpm_cntw-1:0]  count_r, count_s;
   logic                 ovf_r, ovf_s;
   logic [lpm_width-1:0] result_r, result_s;
   logic [lpm_cntw-1:0]  beat_count_r, beat_count_s;
   logic                 cnt_ovf_r, cnt_ovf_s;
   logic                 orphan_r, orphan_s;
   logic                 abort_r, abort_s;
   logic                 accept_s;
   logic                 fresh_s;
   logic [lpm_width-1:0] beat_s;
   logic [lpm_cntw-1:0]  count_inc_s;
   logic                 count_sat_s;

   assign in_ready     = (state_r != ST_HOLD) | result_ready;
   assign result_valid = (state_r == ST_HOLD);
   assign result       = result_r;
   assign beat_count   = beat_count_r;
   assign cnt_ovf      = cnt_ovf_r;
   assign err_orphan   = orphan_r;
   assign err_abort    = abort_r;

   // Beat fold and saturating count increment.
   always_comb begin
      accept_s    = in_valid & in_ready;
      beat_s      = beat_xor(data);
      count_sat_s = (count_r == cnt_max_c);
      if (count_sat_s) begin
         count_inc_s = count_r;
      end else begin
         count_inc_s = count_r + cnt_one_c;
      end
   end

   // Next-state and datapath update; fresh_s marks a beat that opens a frame
   // from a frame-less context (IDLE, retiring HOLD, or abort in ACCUM).
   always_comb begin
      state_s      = state_r;
      acc_s        = acc_r;
      count_s      = count_r;
      ovf_s        = ovf_r;
      result_s     = result_r;
      beat_count_s = beat_count_r;
      cnt_ovf_s    = cnt_ovf_r;
      orphan_s     = 1'b0;
      abort_s      = 1'b0;
      fresh_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            fresh_s = accept_s;
         end
         ST_ACCUM: begin
            if (accept_s) begin
               if (in_sop) begin
                  abort_s = 1'b1;
                  fresh_s = 1'b1;
               end else if (in_eop) begin
                  state_s      = ST_HOLD;
                  result_s     = out_pol(acc_r ^ beat_s);
                  beat_count_s = count_inc_s;
                  cnt_ovf_s    = ovf_r | count_sat_s;
               end else begin
                  acc_s   = acc_r ^ beat_s;
                  count_s = count_inc_s;
                  ovf_s   = ovf_r | count_sat_s;
               end
            end else begin
               state_s = ST_ACCUM;
            end
         end
         ST_HOLD: begin
            if (result_ready) begin
               state_s = ST_IDLE;
               fresh_s = in_valid;
            end else begin
               state_s = ST_HOLD;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
      if (fresh_s) begin
         if (in_sop) begin
            acc_s   = beat_s;
            count_s = cnt_one_c;
            ovf_s   = 1'b0;
            if (in_eop) begin
               state_s      = ST_HOLD;
               result_s     = out_pol(beat_s);
               beat_count_s = cnt_one_c;
               cnt_ovf_s    = 1'b0;
            end else begin
               state_s = ST_ACCUM;
            end
         end else begin
            orphan_s = 1'b1;
         end
      end else begin
         orphan_s = 1'b0;
      end
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) begin
         state_r      <= ST_IDLE;
         acc_r        <= '0;
         count_r      <= '0;
         ovf_r        <= 1'b0;
         result_r     <= '0;
         beat_count_r <= '0;
         cnt_ovf_r    <= 1'b0;
         orphan_r     <= 1'b0;
         abort_r      <= 1'b0;
      end else begin
         state_r      <= state_s;
         acc_r        <= acc_s;
         count_r      <= count_s;
         ovf_r        <= ovf_s;
         result_r     <= result_s;
         beat_count_r <= beat_count_s;
         cnt_ovf_r    <= cnt_ovf_s;
         orphan_r     <= orphan_s;
         abort_r      <= abort_s;
      end
   end

endmodule

// File: tb/tb_lpm_xor_acc.sv
// Bench for lpm_xor_acc: two instances share stimulus, one XOR with a 2-bit
// beat counter and one XNOR with an 8-bit counter. A frame-level reference
// model runs alongside a hand-written vector table and directed sequences.
module tb_lpm_xor_acc;

   logic        clock = 1'b0;
   logic        aclr_n;
   logic [31:0] data;
   logic        in_valid, in_sop, in_eop, result_ready;

   logic       rdy_a, rv_a, ovf_a, orph_a, abt_a;
   logic [7:0] res_a;
   logic [1:0] cnt_a;
   logic       rdy_b, rv_b, ovf_b, orph_b, abt_b;
   logic [7:0] res_b;
   logic [7:0] cnt_b;

   int applied = 0;
   int miscompares = 0;

   // reference model state
   bit         m_hold, m_inf, m_orph, m_abt;
   logic [7:0] m_hx, m_fx;
   int         m_hlen, m_flen;
   logic       rdy_seen;

   always #5 clock = ~clock;

   lpm_xor_acc #(.lpm_width(8), .lpm_size(4), .lpm_cntw(2), .lpm_mode("XOR")) dut_a (
      .clock(clock), .aclr_n(aclr_n), .data(data), .in_valid(in_valid),
      .in_sop(in_sop), .in_eop(in_eop), .in_ready(rdy_a), .result(res_a),
      .result_valid(rv_a), .result_ready(result_ready), .beat_count(cnt_a),
      .cnt_ovf(ovf_a), .err_orphan(orph_a), .err_abort(abt_a));

   lpm_xor_acc #(.lpm_width(8), .lpm_size(4), .lpm_cntw(8), .lpm_mode("XNOR")) dut_b (
      .clock(clock), .aclr_n(aclr_n), .data(data), .in_valid(in_valid),
      .in_sop(in_sop), .in_eop(in_eop), .in_ready(rdy_b), .result(res_b),
      .result_valid(rv_b), .result_ready(result_ready), .beat_count(cnt_b),
      .cnt_ovf(ovf_b), .err_orphan(orph_b), .err_abort(abt_b));

   typedef struct {
      logic [7:0] x;
      logic       v, s, e, rr;
      logic       rdy, rv;
      logic [7:0] res;
      logic [1:0] cnt;
      logic       ovf, orph, abt;
   } row_t;

   row_t tbl[22];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      applied++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // payload whose four bytes fold to x, touching every word lane
   function automatic logic [31:0] mk(input logic [7:0] x);
      logic [7:0] k1, k2;
      k1 = 8'h5A;
      k2 = 8'h33;
      return {x ^ k1, k1, k2, k2};
   endfunction

   task automatic model_reset();
      m_hold = 1'b0; m_inf = 1'b0; m_orph = 1'b0; m_abt = 1'b0;
      m_hx = 8'h00; m_fx = 8'h00; m_hlen = 0; m_flen = 0;
   endtask

   task automatic model_step(input logic [31:0] d, input logic v, s, e, rr);
      logic [7:0] r;
      bit         acc;
      r = d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
      acc = v && (!m_hold || rr);
      m_orph = 1'b0;
      m_abt  = 1'b0;
      if (m_hold && rr) m_hold = 1'b0;
      if (acc) begin
         if (s) begin
            if (m_inf) m_abt = 1'b1;
            m_inf = 1'b1; m_fx = r; m_flen = 1;
         end else if (m_inf) begin
            m_fx = m_fx ^ r; m_flen++;
         end else begin
            m_orph = 1'b1;
         end
         if (e && m_inf) begin
            m_hold = 1'b1; m_hx = m_fx; m_hlen = m_flen; m_inf = 1'b0;
         end
      end
   endtask

   task automatic check_model();
      logic [7:0] xn;
      int ca, cb;
      xn = ~m_hx;
      ca = (m_hlen > 3) ? 3 : m_hlen;
      cb = (m_hlen > 255) ? 255 : m_hlen;
      chk("model_rv_a", rv_a, m_hold);
      chk("model_rv_b", rv_b, m_hold);
      chk("model_orphan_a", orph_a, m_orph);
      chk("model_orphan_b", orph_b, m_orph);
      chk("model_abort_a", abt_a, m_abt);
      chk("model_abort_b", abt_b, m_abt);
      if (m_hold) begin
         chk("model_result_a", res_a, m_hx);
         chk("model_result_b", res_b, xn);
         chk("model_count_a", cnt_a, ca);
         chk("model_count_b", cnt_b, cb);
         chk("model_ovf_a", ovf_a, m_hlen > 3);
         chk("model_ovf_b", ovf_b, m_hlen > 255);
      end
   endtask

   // one cycle: drive at negedge, check ready, step model, check after edge
   task automatic apply(input logic [31:0] d, input logic v, s, e, rr);
      data = d; in_valid = v; in_sop = s; in_eop = e; result_ready = rr;
      #1;
      rdy_seen = rdy_a;
      chk("model_ready_a", rdy_a, !m_hold || rr);
      chk("model_ready_b", rdy_b, !m_hold || rr);
      model_step(d, v, s, e, rr);
      @(negedge clock);
      check_model();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ready"}, {rdy_b, rdy_a}, 32'd3);
      chk({tag, "_rv"}, {rv_b, rv_a}, 32'd0);
      chk({tag, "_result"}, {res_b, res_a}, 32'd0);
      chk({tag, "_count"}, {cnt_b, cnt_a}, 32'd0);
      chk({tag, "_flags"}, {ovf_b, orph_b, abt_b, ovf_a, orph_a, abt_a}, 32'd0);
   endtask

   // asynchronous clear pulse placed between clock edges
   task automatic async_reset();
      @(posedge clock);
      #3;
      aclr_n = 1'b0;
      data = 32'h0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; result_ready = 1'b0;
      #1;
      check_zero("reset_async");
      model_reset();
      #3;
      aclr_n = 1'b1;
      @(negedge clock);
   endtask

   initial begin
      tbl[0]  = '{8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{8'h44, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h77, 2'd3, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77, 2'd3, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{8'h99, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1, 1'b0};
      tbl[6]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{8'h10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1};
      tbl[10] = '{8'h20, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h30, 2'd2, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0};
      tbl[12] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0};
      tbl[13] = '{8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0};
      tbl[14] = '{8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0};
      tbl[15] = '{8'h08, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0};
      tbl[16] = '{8'h10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h1F, 2'd3, 1'b1, 1'b0, 1'b0};
      tbl[17] = '{8'hAA, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h1F, 2'd3, 1'b1, 1'b0, 1'b0};
      tbl[18] = '{8'h03, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0};
      tbl[19] = '{8'h05, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h06, 2'd2, 1'b0, 1'b0, 1'b0};
      tbl[20] = '{8'h77, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1, 1'b0};
      tbl[21] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0};

      // power-on clear
      aclr_n = 1'b0;
      data = 32'h0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; result_ready = 1'b0;
      model_reset();
      #2;
      check_zero("reset_init");
      #10;
      aclr_n = 1'b1;
      @(negedge clock);
      check_zero("after_reset");

      // vector table: frames, retire, orphan, abort, saturation, back-pressure
      for (int i = 0; i < 22; i++) begin
         logic [7:0] xn;
         apply(mk(tbl[i].x), tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].rr);
         xn = ~tbl[i].res;
         chk($sformatf("tbl%0d_ready", i), rdy_seen, tbl[i].rdy);
         chk($sformatf("tbl%0d_rv", i), rv_a, tbl[i].rv);
         chk($sformatf("tbl%0d_orphan", i), orph_a, tbl[i].orph);
         chk($sformatf("tbl%0d_abort", i), abt_a, tbl[i].abt);
         if (tbl[i].rv) begin
            chk($sformatf("tbl%0d_result_a", i), res_a, tbl[i].res);
            chk($sformatf("tbl%0d_result_b", i), res_b, xn);
            chk($sformatf("tbl%0d_count", i), cnt_a, tbl[i].cnt);
            chk($sformatf("tbl%0d_ovf", i), ovf_a, tbl[i].ovf);
         end
      end

      // asynchronous clear mid-frame, then a clean two-beat frame
      apply(mk(8'h55), 1'b1, 1'b1, 1'b0, 1'b0);
      apply(mk(8'h66), 1'b1, 1'b0, 1'b0, 1'b0);
      async_reset();
      apply(mk(8'h0C), 1'b1, 1'b1, 1'b0, 1'b0);
      chk("rst_no_result", rv_a, 1'b0);
      apply(mk(8'h30), 1'b1, 1'b0, 1'b1, 1'b0);
      chk("rst_frame_rv", rv_a, 1'b1);
      chk("rst_frame_result", res_a, 8'h3C);
      chk("rst_frame_count", cnt_a, 2'd2);

      // held result under back-pressure with a single-beat frame waiting
      for (int k = 0; k < 5; k++) begin
         apply(mk(8'h0F), 1'b1, 1'b1, 1'b1, 1'b0);
         chk("bp_ready_low", rdy_seen, 1'b0);
         chk("bp_result_stable", res_a, 8'h3C);
         chk("bp_count_stable", cnt_a, 2'd2);
         chk("bp_rv_high", rv_a, 1'b1);
      end
      apply(mk(8'h0F), 1'b1, 1'b1, 1'b1, 1'b1);
      chk("bp_release_ready", rdy_seen, 1'b1);
      chk("single_rv", rv_b, 1'b1);
      chk("single_result_xor", res_a, 8'h0F);
      chk("single_result_xnor", res_b, 8'hF0);
      chk("single_count_xnor", cnt_b, 8'd1);
      chk("single_ovf", ovf_a, 1'b0);
      apply(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("single_retired", rv_a, 1'b0);

      // randomized traffic against the frame-level model
      for (int n = 0; n < 800; n++) begin
         logic v, s, e, rr;
         v  = ($urandom_range(3, 0) != 0);
         s  = ($urandom_range(4, 0) == 0);
         e  = ($urandom_range(3, 0) == 0);
         rr = ($urandom_range(2, 0) != 0);
         apply($urandom, v, s, e, rr);
      end

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
